// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the serial "1101" frame scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   ctrl_state_e : frame controller states (IDLE/SHIFT/FLUSH/DONE)
//   core_state_e : detector core states (S0..S4, S4 = match)
//   PATTERN      : the detected bit sequence, first bit in the MSB
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } core_state_e;

    // Bit 3 is seen first on the serial stream.
    localparam logic [3:0] PATTERN = 4'b1101;

endpackage : seq_scan_pkg

// File: rtl/det1101_core.sv
// Bit-serial Moore detector for the "1101" pattern with overlapping matches.
// Latency: match is registered state, so it reflects a bit one cycle after that bit is enabled in.
// Backpressure: none; en=0 freezes the state, which is how the caller stalls it.
//
// Ports:
//   clk    in  1  rising-edge clock
//   reset  in  1  asynchronous active-low reset, forces S0
//   en     in  1  consume bit_in this cycle
//   bit_in in  1  serial data bit
//   match  out 1  high while in S4 (last consumed bits were 1,1,0,1)
module det1101_core
    import seq_scan_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic bit_in,
    output logic match
);

    core_state_e state_q;
    core_state_e state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                S0: state_d = (bit_in == PATTERN[3]) ? S1 : S0;
                S1: state_d = (bit_in == PATTERN[2]) ? S2 : S0;
                // A surplus 1 after "11" still leaves a valid "11" prefix.
                S2: state_d = (bit_in == PATTERN[1]) ? S3 : S2;
                S3: state_d = (bit_in == PATTERN[0]) ? S4 : S0;
                // Overlap: the trailing 1 of a match plus a new 1 is "11".
                S4: state_d = bit_in ? S2 : S0;
                default: state_d = S0;
            endcase
        end
    end

    assign match = (state_q == S4);

endmodule : det1101_core

// File: rtl/seq_scan_ctrl.sv
// Frame controller: takes parallel words, serialises them MSB-first into det1101_core, counts matches per frame.
// Latency: out_valid rises WORD_W+2 cycles after the accept of a frame's last word; one word per WORD_W+1 cycles max.
// Backpressure: in_ready only in IDLE; result held in DONE (in_ready=0) until out_ready.
//
// Ports:
//   clk        in  1       rising-edge clock
//   reset      in  1       asynchronous active-low reset
//   in_valid   in  1       word available
//   in_ready   out 1       word accepted this cycle (IDLE only)
//   in_data    in  WORD_W  word, MSB serialised first
//   in_last    in  1       word closes the frame
//   out_valid  out 1       frame result valid (DONE)
//   out_ready  in  1       consumer takes the result
//   hit_cnt    out CNT_W   saturating match count for the frame
//   hit        out 1       one-cycle pulse per newly detected match
//   first_pos  out POS_W   frame bit index of the bit completing the first match
// Build option: define SEQ_SCAN_FIRST_POS_EN to build the first_pos tracker;
// otherwise first_pos is tied to 0.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 8,
    parameter int POS_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic              hit,
    output logic [POS_W-1:0]  first_pos
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    ctrl_state_e       state_q,   state_d;
    logic [WORD_W-1:0] shreg_q,   shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              last_q,    last_d;
    logic              open_q,    open_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              en_q;

    logic core_en;
    logic core_bit;
    logic match;
    logic accept;
    logic new_frame;
    logic hit_w;

    det1101_core u_core (
        .clk    (clk),
        .reset  (reset),
        .en     (core_en),
        .bit_in (core_bit),
        .match  (match)
    );

    // ------------------------------------------------------------------
    // Controller FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            last_q    <= 1'b0;
            open_q    <= 1'b0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            last_q    <= last_d;
            open_q    <= open_d;
            cnt_q     <= cnt_d;
            en_q      <= core_en;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        last_d    = last_q;
        open_d    = open_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        core_en   = 1'b0;
        core_bit  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_d   = in_data;
                    last_d    = in_last;
                    bit_idx_d = IDX_W'(WORD_W - 1);
                    open_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                core_en   = 1'b1;
                core_bit  = shreg_q[WORD_W-1];
                shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                bit_idx_d = bit_idx_q - IDX_W'(1);
                if (bit_idx_q == '0) begin
                    // A non-last word leaves the frame open and the core
                    // state intact, so matches can straddle words.
                    state_d = last_q ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                // Zeros fed here and in DONE walk any core state back to S0
                // (at most two zeros needed) without ever reaching S4, so the
                // next frame starts from a clean core and no spurious hit is
                // produced. DONE always lasts at least one cycle.
                core_en  = 1'b1;
                core_bit = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                core_en   = 1'b1;
                core_bit  = 1'b0;
                if (out_ready) begin
                    open_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign new_frame = accept & ~open_q;

    // match reflects the bit enabled one cycle earlier; gating with the
    // registered enable counts every matched bit exactly once, including the
    // final bit of a non-last word, which surfaces in IDLE.
    assign hit_w = match & en_q;
    assign hit   = hit_w;

    // ------------------------------------------------------------------
    // Saturating match counter, cleared when a new frame opens
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (new_frame) begin
            cnt_d = '0;
        end else if (hit_w && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign hit_cnt = cnt_q;

    // ------------------------------------------------------------------
    // First-match position tracker
    // ------------------------------------------------------------------
`ifdef SEQ_SCAN_FIRST_POS_EN
    logic [POS_W-1:0] pos_q,     pos_d;      // index of the next bit to shift
    logic [POS_W-1:0] cur_pos_q, cur_pos_d;  // index of the bit just shifted
    logic [POS_W-1:0] fpos_q,    fpos_d;
    logic             found_q,   found_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q     <= '0;
            cur_pos_q <= '0;
            fpos_q    <= '0;
            found_q   <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            cur_pos_q <= cur_pos_d;
            fpos_q    <= fpos_d;
            found_q   <= found_d;
        end
    end

    always_comb begin
        pos_d     = pos_q;
        cur_pos_d = cur_pos_q;
        fpos_d    = fpos_q;
        found_d   = found_q;
        if (new_frame) begin
            pos_d   = '0;
            fpos_d  = '0;
            found_d = 1'b0;
        end else begin
            if (state_q == SHIFT) begin
                cur_pos_d = pos_q;
                if (pos_q != {POS_W{1'b1}}) begin
                    pos_d = pos_q + POS_W'(1);
                end
            end
            // The hit for a bit arrives one cycle after it is shifted, when
            // cur_pos_q still names that bit.
            if (hit_w && !found_q) begin
                fpos_d  = cur_pos_q;
                found_d = 1'b1;
            end
        end
    end

    assign first_pos = fpos_q;
`else
    assign first_pos = '0;
`endif

endmodule : seq_scan_ctrl

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: a default instance plus a CNT_W=2
// instance driven by the same stimulus for the saturation case.
module tb_seq_scan_ctrl;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 8;
    localparam int POS_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  hit_cnt;
    logic              hit;
    logic [POS_W-1:0]  first_pos;

    logic              s_in_ready;
    logic              s_out_valid;
    logic [1:0]        s_hit_cnt;
    logic              s_hit;
    logic [POS_W-1:0]  s_first_pos;

    int n_chk = 0;
    int n_err = 0;
    int hit_total = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W), .POS_W(POS_W)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hit_cnt   (hit_cnt),
        .hit       (hit),
        .first_pos (first_pos)
    );

    seq_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(2), .POS_W(POS_W)) u_sat (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (s_in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (s_out_valid),
        .out_ready (out_ready),
        .hit_cnt   (s_hit_cnt),
        .hit       (s_hit),
        .first_pos (s_first_pos)
    );

    always @(negedge clk) begin
        if (hit) hit_total++;
    end

    function automatic int fp(input int v);
`ifdef SEQ_SCAN_FIRST_POS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Present a word and hold it until the handshake completes.
    task automatic send_word(input logic [WORD_W-1:0] d, input logic l);
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after an accept; cyc counts the accept cycle as 0.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!out_valid) chk("done_timeout", 0, 1);
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_out_valid", int'(out_valid), 0);
    endtask

    typedef struct {
        string             name;
        logic [WORD_W-1:0] w0;
        logic [WORD_W-1:0] w1;
        logic [WORD_W-1:0] w2;
        int                nw;
        int                raw;   // matches in the bitstream (pulse count)
        int                sat;   // hit_cnt with CNT_W=2
        int                fpos;  // first_pos with the tracker built
    } vec_t;

    vec_t vecs[8];

    initial begin
        int   cyc;
        int   h0;
        logic [31:0] mask;
        logic [WORD_W-1:0] wd;

        vecs[0] = '{"cross_word",   8'h03, 8'h40, 8'h00, 2, 1, 1, 9};
        vecs[1] = '{"saturate",     8'hDD, 8'hDD, 8'hDD, 3, 6, 3, 3};
        vecs[2] = '{"all_zero",     8'h00, 8'h00, 8'h00, 1, 0, 0, 0};
        vecs[3] = '{"all_ones",     8'hFF, 8'h00, 8'h00, 1, 0, 0, 0};
        vecs[4] = '{"tail_match",   8'h0D, 8'h00, 8'h00, 1, 1, 1, 7};
        vecs[5] = '{"mid_match",    8'hB6, 8'h00, 8'h00, 1, 1, 1, 5};
        vecs[6] = '{"nonlast_tail", 8'h0D, 8'h00, 8'h00, 2, 1, 1, 7};
        vecs[7] = '{"straddle",     8'h06, 8'h80, 8'h00, 2, 1, 1, 8};

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_hit_cnt", int'(hit_cnt), 0);
        chk("rst_first_pos", int'(first_pos), 0);
        @(negedge clk);
        reset = 1'b1;

        // Single last word 1101_1010: hits on bits 3 and 6, each visible one
        // cycle after the bit is shifted (bit i shifts in cycle i+1).
        send_word(8'hDA, 1'b1);
        cyc  = 1;
        mask = '0;
        while (!out_valid && cyc < 100) begin
            if (hit) mask[cyc] = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t1_latency", cyc, WORD_W + 2);
        chk("t1_hit_mask", int'(mask), (1 << 5) | (1 << 8));
        chk("t1_hit_cnt", int'(hit_cnt), 2);
        chk("t1_first_pos", int'(first_pos), fp(3));
        release_out();

        // Table of frames
        for (int i = 0; i < 8; i++) begin
            h0 = hit_total;
            for (int w = 0; w < vecs[i].nw; w++) begin
                wd = (w == 0) ? vecs[i].w0 : ((w == 1) ? vecs[i].w1 : vecs[i].w2);
                send_word(wd, (w == vecs[i].nw - 1));
            end
            wait_done(cyc);
            chk({vecs[i].name, "_out_valid"}, int'(out_valid), 1);
            chk({vecs[i].name, "_latency"}, cyc, WORD_W + 2);
            chk({vecs[i].name, "_hit_cnt"}, int'(hit_cnt), vecs[i].raw);
            chk({vecs[i].name, "_sat_cnt"}, int'(s_hit_cnt), vecs[i].sat);
            chk({vecs[i].name, "_first_pos"}, int'(first_pos), fp(vecs[i].fpos));
            chk({vecs[i].name, "_pulses"}, hit_total - h0, vecs[i].raw);
            release_out();
        end

        // Backpressure: result held while out_ready stays low
        send_word(8'hB6, 1'b1);
        wait_done(cyc);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_hit_cnt", int'(hit_cnt), 1);
            chk("bp_first_pos", int'(first_pos), fp(5));
            chk("bp_in_ready", int'(in_ready), 0);
        end
        release_out();

        // Reset during the 4th SHIFT cycle of 8'hDD
        send_word(8'hDD, 1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("mid_in_ready_shift", int'(in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_hit", int'(hit), 0);
        chk("mid_rst_hit_cnt", int'(hit_cnt), 0);
        chk("mid_rst_first_pos", int'(first_pos), 0);
        @(negedge clk);
        reset = 1'b1;
        send_word(8'h0D, 1'b1);
        wait_done(cyc);
        chk("post_rst_latency", cyc, WORD_W + 2);
        chk("post_rst_hit_cnt", int'(hit_cnt), 1);
        chk("post_rst_first_pos", int'(first_pos), fp(7));
        release_out();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_seq_scan_ctrl
